// File: rtl/uart_msg_serialiser.sv
// uart_msg_serialiser
//    Latches one fixed-width message from the system controller and streams it
//    to the UART transmitter MSB-first, one byte per transfer.
//    Counts completed messages with a wrapping 16-bit counter.
//
// Parameters
//    MSG_BYTES       message length in bytes (2..16); the header is the top byte
//
// Ports
//    clk             system clock, rising edge
//    reset           synchronous, active-high
//    uart_out_msg    message to send, sampled only on an accepting cycle
//    uart_out_req    send request; accepted when uart_out_req && uart_out_ready
//    uart_out_ready  registered, high only when idle
//    tx_data         byte to the transmitter
//    tx_valid        tx_data is valid
//    tx_ready        transmitter takes the byte when tx_valid && tx_ready
//    msgs_sent       count of fully transmitted messages, wraps at 0xFFFF
//
// Build option
//    UART_TX_CHECKSUM_EN  when defined, an 8-bit XOR of the message bytes is
//                         appended as one trailing byte.
//
// State     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | ready for a new message, tx_valid low
// ST_SEND   | presenting message bytes, MSB first
// ST_CHECK  | presenting the checksum byte (checksum build only)

module uart_msg_serialiser #(
   parameter int MSG_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*MSG_BYTES-1:0] uart_out_msg,
   input  logic                   uart_out_req,
   output logic                   uart_out_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [15:0]            msgs_sent
);

   localparam int MW = 8 * MSG_BYTES;
   localparam int CW = $clog2(MSG_BYTES);
   localparam logic [CW-1:0] LAST_IDX = CW'(MSG_BYTES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef UART_TX_CHECKSUM_EN
   localparam logic [1:0] ST_CHECK = 2'd2;
`endif

   logic [1:0]    state_q, state_d;
   logic [MW-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          ready_q, ready_d;
   logic [15:0]   msgs_q,  msgs_d;
`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]    csum_q,  csum_d;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      msgs_d  = msgs_q;
`ifdef UART_TX_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ready_q && uart_out_req) begin
               shift_d = uart_out_msg;
               cnt_d   = '0;
`ifdef UART_TX_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               shift_d = shift_q << 8;
`ifdef UART_TX_CHECKSUM_EN
               csum_d  = csum_q ^ shift_q[MW-1 -: 8];
`endif
               if (cnt_q == LAST_IDX) begin
                  // Clear rather than wrap so non-power-of-two sizes stay in range.
                  cnt_d = '0;
`ifdef UART_TX_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_IDLE;
                  msgs_d  = msgs_q + 16'd1;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`ifdef UART_TX_CHECKSUM_EN
         ST_CHECK: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
               msgs_d  = msgs_q + 16'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      // Looking at the next state keeps ready low on the accept edge and
      // raises it the cycle after the final transfer.
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         msgs_q  <= 16'd0;
`ifdef UART_TX_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         msgs_q  <= msgs_d;
`ifdef UART_TX_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
`ifdef UART_TX_CHECKSUM_EN
      tx_valid = (state_q == ST_SEND) || (state_q == ST_CHECK);
      tx_data  = (state_q == ST_CHECK) ? csum_q : shift_q[MW-1 -: 8];
`else
      tx_valid = (state_q == ST_SEND);
      tx_data  = shift_q[MW-1 -: 8];
`endif
   end

   assign uart_out_ready = ready_q;
   assign msgs_sent      = msgs_q;

endmodule

// File: doc/uart_msg_serialiser.md
# uart_msg_serialiser

Downstream of the system controller: accepts one complete fixed-width UART message per handshake on the controller's output message port and emits it as a byte stream to the UART transmitter. It latches the message, so the controller may change `uart_out_msg` after the accepting cycle. It applies byte-level flow control from the transmitter and keeps a wrapping count of messages sent.

## Interface
- `MSG_BYTES`, default 4: message length in bytes, 2..16. The header is the most-significant byte.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `uart_out_msg` input 8*MSG_BYTES: message from the controller. Sampled only on an accepting cycle.
- `uart_out_req` input 1: send request. A message is accepted when `uart_out_req && uart_out_ready`.
- `uart_out_ready` output 1: registered. High only when idle and able to accept a message.
- `tx_data` output 8: byte to the UART transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter accepts the byte. A byte transfers when `tx_valid && tx_ready`.
- `msgs_sent` output 16: count of fully transmitted messages. Wraps from 0xFFFF to 0x0000.

## Operation
States:
- **IDLE**
  - `uart_out_ready`=1, `tx_valid`=0.
  - On accept: latch `uart_out_msg` into the shift register, clear the byte counter, go to SEND.
  - A request while `uart_out_ready`=0 is ignored and nothing is latched.
- **SEND**
  - `tx_valid`=1.
  - `tx_data` = the current byte, MSB-first: byte 0 is `uart_out_msg[8*MSG_BYTES-1 -: 8]`.
  - On each transfer: shift left 8 and increment the counter.
  - After byte MSG_BYTES-1 transfers:
    - go to CHECK if the checksum is enabled;
    - otherwise go to IDLE and increment `msgs_sent`.
- **CHECK** (checksum build only)
  - `tx_valid`=1, `tx_data` = running checksum.
  - On transfer: go to IDLE and increment `msgs_sent`.

Rules:
- Byte counter width is `$clog2(MSG_BYTES)`. It never exceeds MSG_BYTES-1.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold unchanged. There is no timeout.
- `uart_out_ready` stays 0 in SEND and CHECK. `uart_out_msg` and `uart_out_req` are don't-care there.
- Reset mid-message:
  - abort immediately;
  - the partial message is discarded and not retransmitted;
  - `msgs_sent` is cleared.
- Reset values:
  - state IDLE;
  - `uart_out_ready`=0 (it rises on the first cycle after reset deasserts);
  - `tx_valid`=0, `tx_data`=0x00, `msgs_sent`=0;
  - shift register and checksum = 0.

## Timing
- Accept at edge N gives `tx_valid`=1 with byte 0 from cycle N+1.
- With `tx_ready` held at 1:
  - bytes occupy cycles N+1..N+MSG_BYTES, plus one more cycle for the checksum if enabled;
  - `uart_out_ready` returns 1 on the cycle after the last transfer.
  - Minimum message period is MSG_BYTES+1 cycles, or MSG_BYTES+2 with the checksum.
- `msgs_sent` updates on the same edge as the final transfer.
- No combinational path from any input to `uart_out_ready` or `tx_valid`.
- `tx_data` is a function of registered state only.

## Configuration
- Macro: `UART_TX_CHECKSUM_EN`.
- Defined:
  - A running 8-bit XOR of all message bytes is seeded to 0x00 on accept and updated as each byte transfers.
  - It is sent as one extra trailing byte from state CHECK.
- Undefined:
  - CHECK and the checksum register do not exist.
  - Exactly MSG_BYTES bytes are sent per message.

## Test plan
- **Basic send.** MSG_BYTES=4, `uart_out_msg`=0xA1B2C3D4, `tx_ready`=1.
  - Required: bytes A1, B2, C3, D4 on consecutive cycles.
  - With checksum: a fifth byte 0x04.
  - `msgs_sent` 0→1; `uart_out_ready` high one cycle after the last byte.
- **Back-pressure.** Same message, `tx_ready` low for 3 cycles while byte B2 is presented.
  - Required: B2 held stable for 4 cycles, then C3, D4 follow.
  - No byte lost or duplicated.
- **Request while busy.** Pulse `uart_out_req` with 0x11223344 during SEND of 0xA1B2C3D4.
  - Required: only A1 B2 C3 D4 are emitted; `msgs_sent` increments by 1.
- **Back-to-back.** Hold `uart_out_req` high with 0x01020304, then 0x05060708 on the next accept.
  - Required: 8 (or 10) bytes in order, with exactly one idle cycle between messages.
- **Reset mid-message.** Assert `reset` after byte B2 transfers.
  - Required: `tx_valid`=0 and `uart_out_ready`=0 in the cycle after the reset edge.
  - `msgs_sent`=0; after release, the next message starts from byte 0.
- **Counter wrap.** Force `msgs_sent`=0xFFFF by sending 65535 messages.
  - Required: the next completed message gives 0x0000.
